// File: rtl/lotr_pkg.sv
// rtl/lotr_pkg.sv - shared ring message types and field positions for the request ring
// Contents:
//   t_opcode    : request opcode carried on the ring
//   t_ring_msg  : one ring slot payload {requestor, opcode, address, data}
//   t_slot_sel  : source selected for the outgoing ring slot
//   RING_DEST_* : destination core field inside the address
package lotr_pkg;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_LOAD  = 3'd1,
    OP_STORE = 3'd2,
    OP_AMO   = 3'd3,
    OP_FLUSH = 3'd4
  } t_opcode;

  typedef struct packed {
    logic [9:0]  requestor;  // {core[7:0], thread[1:0]}
    t_opcode     opcode;
    logic [31:0] address;
    logic [31:0] data;
  } t_ring_msg;

  typedef enum logic [1:0] {
    SEL_IDLE   = 2'd0,
    SEL_PASS   = 2'd1,
    SEL_INJECT = 2'd2
  } t_slot_sel;

  localparam int RING_DEST_MSB = 31;
  localparam int RING_DEST_LSB = 24;

endpackage

// File: rtl/ring_inject_fifo.sv
// rtl/ring_inject_fifo.sv - local inject queue holding ring messages in arrival order
// Ports:
//   QClk, RstQnnnH : clock, synchronous active-high reset (empties the queue)
//   push_i         : write push_msg_i at the tail (caller guarantees not full)
//   pop_i          : drop the head entry (caller guarantees not empty)
//   head_o         : oldest entry; undefined content while empty
//   full_o/empty_o : occupancy flags from the registered count
//   count_o        : number of valid entries, 0..FIFO_DEPTH
module ring_inject_fifo
  import lotr_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          QClk,
  input  logic                          RstQnnnH,
  input  logic                          push_i,
  input  t_ring_msg                     push_msg_i,
  input  logic                          pop_i,
  output t_ring_msg                     head_o,
  output logic                          full_o,
  output logic                          empty_o,
  output logic [$clog2(FIFO_DEPTH):0]   count_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  t_ring_msg       mem_q [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  // Pointers are exactly log2(depth) bits, so they wrap modulo depth for free.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge QClk) begin
    if (RstQnnnH) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible through count.
  always_ff @(posedge QClk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_msg_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(FIFO_DEPTH));

endmodule

// File: rtl/ring_req_inject_arb.sv
// rtl/ring_req_inject_arb.sv - request-ring stop: eject, pass-through and local inject arbitration
// Ports:
//   QClk, RstQnnnH          : clock, synchronous active-high reset
//   CoreID                  : this tile's ID, static after reset
//   RingIn*Q500H            : incoming ring slot (valid + message fields)
//   LocReq*Q500H            : local core request; LocReqReadyQ500H = queue not full
//   RingOut*Q501H           : registered outgoing ring slot, fields 0 when invalid
//   Eject*Q501H             : registered message addressed to this tile, fields 0 when invalid
//   StarveQnnnH             : local queue blocked for STARVE_MAX consecutive cycles
module ring_req_inject_arb
  import lotr_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_MAX = 15
) (
  input  logic        QClk,
  input  logic        RstQnnnH,
  input  logic [7:0]  CoreID,
  input  logic        RingInValidQ500H,
  input  logic [9:0]  RingInRequestorQ500H,
  input  t_opcode     RingInOpcodeQ500H,
  input  logic [31:0] RingInAddressQ500H,
  input  logic [31:0] RingInDataQ500H,
  input  logic        LocReqValidQ500H,
  output logic        LocReqReadyQ500H,
  input  logic [9:0]  LocReqRequestorQ500H,
  input  t_opcode     LocReqOpcodeQ500H,
  input  logic [31:0] LocReqAddressQ500H,
  input  logic [31:0] LocReqDataQ500H,
  output logic        RingOutValidQ501H,
  output logic [9:0]  RingOutRequestorQ501H,
  output t_opcode     RingOutOpcodeQ501H,
  output logic [31:0] RingOutAddressQ501H,
  output logic [31:0] RingOutDataQ501H,
  output logic        EjectValidQ501H,
  output logic [9:0]  EjectRequestorQ501H,
  output t_opcode     EjectOpcodeQ501H,
  output logic [31:0] EjectAddressQ501H,
  output logic [31:0] EjectDataQ501H,
  output logic        StarveQnnnH
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  t_ring_msg  ring_in, loc_msg, fifo_head;
  logic       fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [CW-1:0] fifo_count;

  logic [7:0] in_dest;
  logic       ring_hit;
  t_slot_sel  slot_sel;

  t_ring_msg  ring_out_q, ring_out_d;
  logic       ring_out_valid_q, ring_out_valid_d;
  t_ring_msg  eject_q, eject_d;
  logic       eject_valid_q, eject_valid_d;
  logic [SW-1:0] starve_cnt_q, starve_cnt_d;
  logic       starve_q, starve_d;

  always_comb begin
    ring_in.requestor = RingInRequestorQ500H;
    ring_in.opcode    = RingInOpcodeQ500H;
    ring_in.address   = RingInAddressQ500H;
    ring_in.data      = RingInDataQ500H;
    loc_msg.requestor = LocReqRequestorQ500H;
    loc_msg.opcode    = LocReqOpcodeQ500H;
    loc_msg.address   = LocReqAddressQ500H;
    loc_msg.data      = LocReqDataQ500H;
  end

  assign LocReqReadyQ500H = !fifo_full;
  assign fifo_push        = LocReqValidQ500H && LocReqReadyQ500H;
  assign fifo_pop         = (slot_sel == SEL_INJECT);

  // A push only lands in the queue at the clock edge, so the head seen here
  // never contains this cycle's push: a fresh request is never bypassed.
  ring_inject_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .QClk       (QClk),
    .RstQnnnH   (RstQnnnH),
    .push_i     (fifo_push),
    .push_msg_i (loc_msg),
    .pop_i      (fifo_pop),
    .head_o     (fifo_head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (fifo_count)
  );

  // Slot selection: an ejected slot counts as free, so eject and inject can
  // share a cycle. Pass-through traffic always wins over the local queue.
  always_comb begin
    in_dest  = RingInAddressQ500H[RING_DEST_MSB:RING_DEST_LSB];
    ring_hit = RingInValidQ500H && (in_dest == CoreID);
    slot_sel = SEL_IDLE;
    if ((!RingInValidQ500H || ring_hit) && !fifo_empty) begin
      slot_sel = SEL_INJECT;
    end else if (RingInValidQ500H && !ring_hit) begin
      slot_sel = SEL_PASS;
    end

    ring_out_d       = '0;
    ring_out_valid_d = 1'b0;
    case (slot_sel)
      SEL_INJECT: begin
        ring_out_d       = fifo_head;
        ring_out_valid_d = 1'b1;
      end
      SEL_PASS: begin
        ring_out_d       = ring_in;
        ring_out_valid_d = 1'b1;
      end
      default: ;
    endcase

    eject_d       = ring_hit ? ring_in : '0;
    eject_valid_d = ring_hit;
  end

  // Blocked-cycle counter: counts only while something waits and nothing leaves.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (fifo_pop || (fifo_count == '0)) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != SW'(STARVE_MAX)) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
    starve_d = (starve_cnt_d == SW'(STARVE_MAX));
  end

  always_ff @(posedge QClk) begin
    if (RstQnnnH) begin
      ring_out_q       <= '0;
      ring_out_valid_q <= 1'b0;
      eject_q          <= '0;
      eject_valid_q    <= 1'b0;
      starve_cnt_q     <= '0;
      starve_q         <= 1'b0;
    end else begin
      ring_out_q       <= ring_out_d;
      ring_out_valid_q <= ring_out_valid_d;
      eject_q          <= eject_d;
      eject_valid_q    <= eject_valid_d;
      starve_cnt_q     <= starve_cnt_d;
      starve_q         <= starve_d;
    end
  end

  assign RingOutValidQ501H     = ring_out_valid_q;
  assign RingOutRequestorQ501H = ring_out_q.requestor;
  assign RingOutOpcodeQ501H    = ring_out_q.opcode;
  assign RingOutAddressQ501H   = ring_out_q.address;
  assign RingOutDataQ501H      = ring_out_q.data;
  assign EjectValidQ501H       = eject_valid_q;
  assign EjectRequestorQ501H   = eject_q.requestor;
  assign EjectOpcodeQ501H      = eject_q.opcode;
  assign EjectAddressQ501H     = eject_q.address;
  assign EjectDataQ501H        = eject_q.data;
  assign StarveQnnnH           = starve_q;

endmodule

// File: tb/tb_ring_req_inject_arb.sv
// tb/tb_ring_req_inject_arb.sv - self-checking bench for ring_req_inject_arb
module tb_ring_req_inject_arb;
  import lotr_pkg::*;

  localparam logic [7:0] CORE = 8'd1;

  logic        QClk = 1'b0;
  logic        RstQnnnH;
  logic [7:0]  CoreID;
  logic        ring_v, loc_v;
  t_ring_msg   ring_msg, loc_msg;
  logic        LocReqReadyQ500H;
  logic        RingOutValidQ501H, EjectValidQ501H, StarveQnnnH;
  logic [9:0]  RingOutRequestorQ501H, EjectRequestorQ501H;
  t_opcode     RingOutOpcodeQ501H, EjectOpcodeQ501H;
  logic [31:0] RingOutAddressQ501H, RingOutDataQ501H, EjectAddressQ501H, EjectDataQ501H;

  int checks = 0;
  int errors = 0;

  t_ring_msg loc_sb[$];
  t_ring_msg pass_sb[$];
  t_ring_msg ej_sb[$];

  always #5 QClk = ~QClk;

  ring_req_inject_arb #(.FIFO_DEPTH(4), .STARVE_MAX(15)) dut (
    .QClk                  (QClk),
    .RstQnnnH              (RstQnnnH),
    .CoreID                (CoreID),
    .RingInValidQ500H      (ring_v),
    .RingInRequestorQ500H  (ring_msg.requestor),
    .RingInOpcodeQ500H     (ring_msg.opcode),
    .RingInAddressQ500H    (ring_msg.address),
    .RingInDataQ500H       (ring_msg.data),
    .LocReqValidQ500H      (loc_v),
    .LocReqReadyQ500H      (LocReqReadyQ500H),
    .LocReqRequestorQ500H  (loc_msg.requestor),
    .LocReqOpcodeQ500H     (loc_msg.opcode),
    .LocReqAddressQ500H    (loc_msg.address),
    .LocReqDataQ500H       (loc_msg.data),
    .RingOutValidQ501H     (RingOutValidQ501H),
    .RingOutRequestorQ501H (RingOutRequestorQ501H),
    .RingOutOpcodeQ501H    (RingOutOpcodeQ501H),
    .RingOutAddressQ501H   (RingOutAddressQ501H),
    .RingOutDataQ501H      (RingOutDataQ501H),
    .EjectValidQ501H       (EjectValidQ501H),
    .EjectRequestorQ501H   (EjectRequestorQ501H),
    .EjectOpcodeQ501H      (EjectOpcodeQ501H),
    .EjectAddressQ501H     (EjectAddressQ501H),
    .EjectDataQ501H        (EjectDataQ501H),
    .StarveQnnnH           (StarveQnnnH)
  );

  function automatic t_ring_msg mk(input logic [7:0] core, input logic [1:0] thr,
                                   input t_opcode op, input logic [31:0] addr,
                                   input logic [31:0] data);
    t_ring_msg m;
    m.requestor = {core, thr};
    m.opcode    = op;
    m.address   = addr;
    m.data      = data;
    return m;
  endfunction

  task automatic tick();
    @(posedge QClk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_out_valid"}, RingOutValidQ501H, 1'b0);
    chk({tag, "_out_addr"}, RingOutAddressQ501H, 32'h0);
    chk({tag, "_out_req"}, RingOutRequestorQ501H, 10'h0);
    chk({tag, "_ej_valid"}, EjectValidQ501H, 1'b0);
    chk({tag, "_ej_addr"}, EjectAddressQ501H, 32'h0);
    chk({tag, "_starve"}, StarveQnnnH, 1'b0);
    chk({tag, "_ready"}, LocReqReadyQ500H, 1'b1);
    chk({tag, "_count"}, dut.u_fifo.count_o, 3'd0);
  endtask

  // Expectations recorded when the DUT captures stimulus; reset flushes them.
  always @(posedge QClk) begin
    if (RstQnnnH) begin
      loc_sb.delete();
      pass_sb.delete();
      ej_sb.delete();
    end else begin
      if (ring_v) begin
        if (ring_msg.address[31:24] == CORE) ej_sb.push_back(ring_msg);
        else pass_sb.push_back(ring_msg);
      end
      if (loc_v) loc_sb.push_back(loc_msg);
    end
  end

  // Local requests carry requestor core CORE, ring traffic uses other cores.
  always @(negedge QClk) begin : monitor
    t_ring_msg got, want;
    if (RingOutValidQ501H) begin
      got.requestor = RingOutRequestorQ501H;
      got.opcode    = RingOutOpcodeQ501H;
      got.address   = RingOutAddressQ501H;
      got.data      = RingOutDataQ501H;
      if (RingOutRequestorQ501H[9:2] == CORE) begin
        if (loc_sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_loc_unexpected: got addr 0x%0h with nothing queued", got.address);
        end else begin
          want = loc_sb.pop_front();
          chk("sb_loc_order", 128'(got), 128'(want));
        end
      end else begin
        if (pass_sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_pass_unexpected: got addr 0x%0h with nothing expected", got.address);
        end else begin
          want = pass_sb.pop_front();
          chk("sb_pass", 128'(got), 128'(want));
        end
      end
    end
    if (EjectValidQ501H) begin
      got.requestor = EjectRequestorQ501H;
      got.opcode    = EjectOpcodeQ501H;
      got.address   = EjectAddressQ501H;
      got.data      = EjectDataQ501H;
      if (ej_sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_eject_unexpected: got addr 0x%0h with nothing expected", got.address);
      end else begin
        want = ej_sb.pop_front();
        chk("sb_eject", 128'(got), 128'(want));
      end
    end
  end

  typedef struct {
    logic        rv;
    logic [31:0] addr;
    logic [31:0] data;
    logic        exp_ov;
    logic [31:0] exp_oaddr;
    logic [31:0] exp_odata;
    logic        exp_ev;
    logic [31:0] exp_eaddr;
    logic [31:0] exp_edata;
  } vec_t;

  vec_t vecs[7];
  int   pass_n;

  initial begin
    vecs[0] = '{1'b1, 32'h0200_0010, 32'h0000_A5A5, 1'b1, 32'h0200_0010, 32'h0000_A5A5, 1'b0, 32'h0, 32'h0};
    vecs[1] = '{1'b1, 32'h0100_0040, 32'h0000_1234, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0100_0040, 32'h0000_1234};
    vecs[2] = '{1'b0, 32'h0200_0077, 32'h0000_FFFF, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0};
    vecs[3] = '{1'b1, 32'hFF00_0000, 32'hDEAD_BEEF, 1'b1, 32'hFF00_0000, 32'hDEAD_BEEF, 1'b0, 32'h0, 32'h0};
    vecs[4] = '{1'b1, 32'h01FF_FFFF, 32'hCAFE_F00D, 1'b0, 32'h0, 32'h0, 1'b1, 32'h01FF_FFFF, 32'hCAFE_F00D};
    vecs[5] = '{1'b1, 32'h0000_0001, 32'h5555_AAAA, 1'b1, 32'h0000_0001, 32'h5555_AAAA, 1'b0, 32'h0, 32'h0};
    vecs[6] = '{1'b1, 32'h0101_0101, 32'h0000_0000, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0101_0101, 32'h0};

    CoreID   = CORE;
    pass_n   = 0;
    // Reset with both request inputs held active.
    RstQnnnH = 1'b1;
    ring_v   = 1'b1;
    ring_msg = mk(8'd7, 2'd0, OP_LOAD, 32'h0200_0000, 32'h1);
    loc_v    = 1'b1;
    loc_msg  = mk(CORE, 2'd0, OP_STORE, 32'h0300_0000, 32'h2);
    repeat (3) tick();
    chk_idle_outputs("reset");
    RstQnnnH = 1'b0;
    ring_v   = 1'b0;
    loc_v    = 1'b0;
    tick();

    // Single-cycle ring vectors with an empty local queue.
    foreach (vecs[i]) begin
      ring_v   = vecs[i].rv;
      ring_msg = mk(8'd7, 2'(i), OP_STORE, vecs[i].addr, vecs[i].data);
      tick();
      chk($sformatf("vec%0d_out_valid", i), RingOutValidQ501H, vecs[i].exp_ov);
      chk($sformatf("vec%0d_out_addr", i), RingOutAddressQ501H, vecs[i].exp_oaddr);
      chk($sformatf("vec%0d_out_data", i), RingOutDataQ501H, vecs[i].exp_odata);
      chk($sformatf("vec%0d_ej_valid", i), EjectValidQ501H, vecs[i].exp_ev);
      chk($sformatf("vec%0d_ej_addr", i), EjectAddressQ501H, vecs[i].exp_eaddr);
      chk($sformatf("vec%0d_ej_data", i), EjectDataQ501H, vecs[i].exp_edata);
    end
    ring_v = 1'b0;
    tick();

    // Eject and inject in the same slot.
    ring_v   = 1'b1;
    ring_msg = mk(8'd7, 2'd0, OP_LOAD, 32'h0300_0000, 32'h11);
    loc_v    = 1'b1;
    loc_msg  = mk(CORE, 2'd1, OP_STORE, 32'h0200_0080, 32'hBEEF);
    tick();
    chk("ei_pass_addr", RingOutAddressQ501H, 32'h0300_0000);
    chk("ei_count_held", dut.u_fifo.count_o, 3'd1);
    loc_v    = 1'b0;
    ring_msg = mk(8'd7, 2'd2, OP_LOAD, 32'h0100_0040, 32'h22);
    tick();
    chk("ei_ej_valid", EjectValidQ501H, 1'b1);
    chk("ei_ej_addr", EjectAddressQ501H, 32'h0100_0040);
    chk("ei_out_valid", RingOutValidQ501H, 1'b1);
    chk("ei_out_addr", RingOutAddressQ501H, 32'h0200_0080);
    ring_v = 1'b0;
    tick();
    chk("ei_after_valid", RingOutValidQ501H, 1'b0);

    // Starvation: ring saturated with pass-through while the queue fills.
    ring_v = 1'b1;
    for (int k = 0; k < 4; k++) begin
      loc_v    = 1'b1;
      loc_msg  = mk(CORE, 2'(k), OP_STORE, 32'h0300_1000 + k, 32'h100 + k);
      ring_msg = mk(8'd7, 2'd3, OP_LOAD, 32'h0200_0000 + pass_n, pass_n);
      pass_n++;
      tick();
    end
    loc_v = 1'b0;
    chk("full_ready", LocReqReadyQ500H, 1'b0);
    chk("full_count", dut.u_fifo.count_o, 3'd4);
    for (int n = 1; n <= 15; n++) begin
      ring_msg = mk(8'd7, 2'd3, OP_LOAD, 32'h0200_0000 + pass_n, pass_n);
      pass_n++;
      tick();
      if (n == 11) chk("starve_before", StarveQnnnH, 1'b0);
      if (n >= 12) chk($sformatf("starve_on_%0d", n), StarveQnnnH, 1'b1);
    end
    ring_v = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("drain%0d_valid", k), RingOutValidQ501H, 1'b1);
      chk($sformatf("drain%0d_addr", k), RingOutAddressQ501H, 32'h0300_1000 + k);
      if (k == 0) begin
        chk("starve_cleared", StarveQnnnH, 1'b0);
        chk("ready_back", LocReqReadyQ500H, 1'b1);
      end
    end
    tick();
    chk("drain_done_valid", RingOutValidQ501H, 1'b0);
    chk("drain_done_count", dut.u_fifo.count_o, 3'd0);

    // No bypass, then push while popping the last entry.
    loc_v   = 1'b1;
    loc_msg = mk(CORE, 2'd0, OP_LOAD, 32'h0400_0000, 32'hA);
    tick();
    chk("nobypass_valid", RingOutValidQ501H, 1'b0);
    chk("nobypass_count", dut.u_fifo.count_o, 3'd1);
    loc_msg = mk(CORE, 2'd1, OP_LOAD, 32'h0400_0004, 32'hB);
    tick();
    chk("pushpop_count", dut.u_fifo.count_o, 3'd1);
    chk("pushpop_out", RingOutAddressQ501H, 32'h0400_0000);
    loc_v = 1'b0;
    tick();
    chk("pushpop_next", RingOutAddressQ501H, 32'h0400_0004);
    chk("pushpop_empty", dut.u_fifo.count_o, 3'd0);

    // Pointer wrap with back-to-back push/pop pairs.
    for (int k = 0; k < 10; k++) begin
      loc_v   = 1'b1;
      loc_msg = mk(CORE, 2'(k), OP_AMO, 32'h0500_0000 + k, $urandom);
      tick();
      if (k > 0) begin
        chk($sformatf("wrap%0d_count", k), dut.u_fifo.count_o, 3'd1);
        chk($sformatf("wrap%0d_addr", k), RingOutAddressQ501H, 32'h0500_0000 + k - 1);
      end
    end
    loc_v = 1'b0;
    tick();
    chk("wrap_last_addr", RingOutAddressQ501H, 32'h0500_0009);
    tick();
    chk("wrap_idle", RingOutValidQ501H, 1'b0);

    // Reset mid-burst with three queued requests.
    ring_v = 1'b1;
    for (int k = 0; k < 3; k++) begin
      loc_v    = 1'b1;
      loc_msg  = mk(CORE, 2'(k), OP_FLUSH, 32'h0600_0000 + k, k);
      ring_msg = mk(8'd7, 2'd1, OP_LOAD, 32'h0200_0000 + pass_n, pass_n);
      pass_n++;
      tick();
    end
    loc_v = 1'b0;
    chk("midrst_count_before", dut.u_fifo.count_o, 3'd3);
    RstQnnnH = 1'b1;
    tick();
    chk_idle_outputs("midrst");
    RstQnnnH = 1'b0;
    ring_v   = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("midrst_noinj%0d", k), RingOutValidQ501H, 1'b0);
    end

    chk("sb_loc_left", loc_sb.size(), 0);
    chk("sb_pass_left", pass_sb.size(), 0);
    chk("sb_eject_left", ej_sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
